mc_control: RTL and testbench

Multi-cycle successor to the single-cycle MIPS control decoder. It latches each fetched instruction and sequences FETCH/DECODE/EXEC/MEM/WB over several cycles, holding memory strobes until a data-memory handshake completes. Syscalls are handled as explicit halt and puts outputs rather than simulation side effects. It sits between the instruction/data memories and the datapath, supplying the same control signal set plus PC/IR write enables.

---
 rtl/mc_control.sv | 227 ++++++++++++++++++++++
 tb/tb_mc_control.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS control sequencer, FETCH/DECODE/EXEC/MEM/WB with absorbing HALT/ERR.
// Latency 2-5 cycles plus MEM wait; stalls in FETCH until instr_valid and in MEM until mem_ready.
module mc_control #(
  parameter int          ALUOP_W   = 3,
  parameter int          WAIT_MAX  = 15,
  parameter int          WAIT_W    = 4,
  parameter logic [31:0] EXIT_CODE = 32'd10,
  parameter logic [31:0] PUTS_CODE = 32'd4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               instr_valid,
  input  logic [31:0]        vreg,
  input  logic               mem_ready,
  output logic               fetch_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         RegDst,
  output logic               Jump,
  output logic               JumpLink,
  output logic               JumpReg,
  output logic               Branch,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               ALUSrc,
  output logic               RegWrite,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               puts_req,
  output logic               halt,
  output logic               illegal,
  output logic               timeout,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(7);

  state_t              cur, nxt;
  logic [31:0]         ir;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic [5:0]          opcode, funct;

  logic                is_nop, is_j, is_jal, is_jr, is_sys;
  logic                is_rtype, is_imm, is_lw, is_sw, is_br, is_mem, is_exec;
  logic [ALUOP_W-1:0]  op_alu;
  logic                op_src;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  // Instruction classification from the latched IR only.
  always_comb begin
    is_j     = 1'b0;
    is_jal   = 1'b0;
    is_jr    = 1'b0;
    is_sys   = 1'b0;
    is_rtype = 1'b0;
    is_imm   = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_br    = 1'b0;
    op_alu   = ALU_AND;
    op_src   = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h08: is_jr = 1'b1;
          6'h0C: is_sys = 1'b1;
          6'h20, 6'h21: begin is_rtype = 1'b1; op_alu = ALU_ADD; end
          6'h22: begin is_rtype = 1'b1; op_alu = ALU_SUB; end
          6'h24: begin is_rtype = 1'b1; op_alu = ALU_AND; end
          6'h25: begin is_rtype = 1'b1; op_alu = ALU_OR;  end
          6'h2A: begin is_rtype = 1'b1; op_alu = ALU_SLT; end
          default: ;
        endcase
      end
      6'h02: is_j = 1'b1;
      6'h03: is_jal = 1'b1;
      6'h04, 6'h05: begin is_br = 1'b1; op_alu = ALU_SUB; end
      6'h08, 6'h09, 6'h0F: begin is_imm = 1'b1; op_alu = ALU_ADD; op_src = 1'b1; end
      6'h0B: begin is_imm = 1'b1; op_alu = ALU_SLT; op_src = 1'b1; end
      6'h0D: begin is_imm = 1'b1; op_alu = ALU_OR;  op_src = 1'b1; end
      6'h23: begin is_lw = 1'b1; op_alu = ALU_ADD; op_src = 1'b1; end
      6'h2B: begin is_sw = 1'b1; op_alu = ALU_ADD; op_src = 1'b1; end
      default: ;
    endcase
  end

  assign is_nop  = (ir == 32'd0);
  assign is_mem  = is_lw | is_sw;
  assign is_exec = is_rtype | is_imm | is_br | is_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= S_FETCH;
      ir       <= 32'd0;
      wait_cnt <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_nxt;
      if (cur == S_FETCH && instr_valid)
        ir <= instr;
    end
  end

  always_comb begin
    nxt       = cur;
    wait_nxt  = wait_cnt;
    fetch_req = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    RegDst    = 2'd0;
    Jump      = 1'b0;
    JumpLink  = 1'b0;
    JumpReg   = 1'b0;
    Branch    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemToReg  = 1'b0;
    ALUSrc    = 1'b0;
    RegWrite  = 1'b0;
    ALUop     = ALU_AND;
    puts_req  = 1'b0;
    halt      = 1'b0;
    illegal   = 1'b0;
    timeout   = 1'b0;
    case (cur)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          // Gated so no IR/PC strobe escapes while reset is held.
          ir_write = rst_n;
          pc_write = rst_n;
          nxt      = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_nop) begin
          nxt = S_FETCH;
        end else if (is_j || is_jal) begin
          Jump     = 1'b1;
          pc_write = 1'b1;
          if (is_jal) begin
            JumpLink = 1'b1;
            RegDst   = 2'd2;
            RegWrite = 1'b1;
          end
          nxt = S_FETCH;
        end else if (is_jr) begin
          JumpReg  = 1'b1;
          pc_write = 1'b1;
          nxt      = S_FETCH;
        end else if (is_sys) begin
          if (vreg == EXIT_CODE) begin
            nxt = S_HALT;
          end else begin
            puts_req = (vreg == PUTS_CODE);
            nxt      = S_FETCH;
          end
        end else if (is_exec) begin
          nxt = S_EXEC;
        end else begin
          nxt = S_ERR;
        end
      end
      S_EXEC: begin
        ALUop  = op_alu;
        ALUSrc = op_src;
        if (is_br) begin
          Branch   = 1'b1;
          pc_write = 1'b1;
          nxt      = S_FETCH;
        end else if (is_mem) begin
          wait_nxt = '0;
          nxt      = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        ALUop    = op_alu;
        ALUSrc   = op_src;
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (mem_ready)
          nxt = is_lw ? S_WB : S_FETCH;
        else if (wait_cnt == WAIT_W'(WAIT_MAX))
          nxt = S_ERR;
        else
          wait_nxt = wait_cnt + WAIT_W'(1);
      end
      S_WB: begin
        ALUop    = op_alu;
        ALUSrc   = op_src;
        RegWrite = 1'b1;
        RegDst   = is_rtype ? 2'd1 : 2'd0;
        MemToReg = is_lw;
        nxt      = S_FETCH;
      end
      S_HALT: halt = 1'b1;
      // ERR is reached from MEM only for loads/stores, otherwise from DECODE.
      S_ERR: begin
        illegal = ~is_mem;
        timeout = is_mem;
      end
      default: nxt = S_FETCH;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: per-instruction expected traces built from the ISA rules.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, vreg;
  logic        instr_valid, mem_ready;
  logic        fetch_req, ir_write, pc_write;
  logic [1:0]  RegDst;
  logic        Jump, JumpLink, JumpReg, Branch;
  logic        MemRead, MemWrite, MemToReg, ALUSrc, RegWrite;
  logic [2:0]  ALUop;
  logic        puts_req, halt, illegal, timeout;
  logic [2:0]  state;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .vreg(vreg), .mem_ready(mem_ready), .fetch_req(fetch_req),
    .ir_write(ir_write), .pc_write(pc_write), .RegDst(RegDst),
    .Jump(Jump), .JumpLink(JumpLink), .JumpReg(JumpReg), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUop(ALUop),
    .puts_req(puts_req), .halt(halt), .illegal(illegal),
    .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       fetch_req, ir_write, pc_write;
    logic [1:0] regdst;
    logic       jump, jlink, jreg, branch;
    logic       mrd, mwr, m2r, asrc, rwr;
    logic [2:0] aluop;
    logic       puts, halt, ill, tmo;
  } ctl_t;

  typedef enum int {C_NOP, C_J, C_JAL, C_JR, C_SYS, C_R, C_I, C_LW, C_SW, C_BR, C_BAD} cls_t;

  localparam logic [2:0] A_AND = 3'd0, A_OR = 3'd1, A_ADD = 3'd2, A_SUB = 3'd6, A_SLT = 3'd7;

  ctl_t obs;
  assign obs = {state, fetch_req, ir_write, pc_write, RegDst, Jump, JumpLink, JumpReg, Branch,
                MemRead, MemWrite, MemToReg, ALUSrc, RegWrite, ALUop, puts_req, halt, illegal, timeout};

  int n_chk = 0;
  int n_pass = 0;

  ctl_t exp_q[$];
  logic iv_q[$];
  logic mr_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic ctl_t base(input logic [2:0] st);
    ctl_t e;
    e = '0;
    e.st = st;
    if (st == 3'd0) e.fetch_req = 1'b1;
    return e;
  endfunction

  function automatic void classify(input logic [31:0] w, output cls_t c,
                                   output logic [2:0] alu, output logic src);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    c = C_BAD; alu = A_AND; src = 1'b0;
    if (w == 32'd0) c = C_NOP;
    else if (op == 6'h00) begin
      case (fn)
        6'h08: c = C_JR;
        6'h0C: c = C_SYS;
        6'h20, 6'h21: begin c = C_R; alu = A_ADD; end
        6'h22: begin c = C_R; alu = A_SUB; end
        6'h24: begin c = C_R; alu = A_AND; end
        6'h25: begin c = C_R; alu = A_OR;  end
        6'h2A: begin c = C_R; alu = A_SLT; end
        default: c = C_BAD;
      endcase
    end else begin
      case (op)
        6'h02: c = C_J;
        6'h03: c = C_JAL;
        6'h04, 6'h05: begin c = C_BR; alu = A_SUB; end
        6'h08, 6'h09, 6'h0F: begin c = C_I; alu = A_ADD; src = 1'b1; end
        6'h0B: begin c = C_I; alu = A_SLT; src = 1'b1; end
        6'h0D: begin c = C_I; alu = A_OR;  src = 1'b1; end
        6'h23: begin c = C_LW; alu = A_ADD; src = 1'b1; end
        6'h2B: begin c = C_SW; alu = A_ADD; src = 1'b1; end
        default: c = C_BAD;
      endcase
    end
  endfunction

  task automatic push(input ctl_t e, input logic iv, input logic mr);
    exp_q.push_back(e);
    iv_q.push_back(iv);
    mr_q.push_back(mr);
  endtask

  task automatic push_terminal(input ctl_t e);
    for (int k = 0; k < 4; k++) push(e, 1'b1, 1'b1);
  endtask

  // Builds the full expected cycle trace of one instruction, then plays it against the DUT.
  task automatic run_txn(input string tag, input logic [31:0] iw, input logic [31:0] vw,
                         input int dly, input int waits, input bit never);
    ctl_t e;
    cls_t c;
    logic [2:0] alu;
    logic src;
    int n;
    exp_q.delete(); iv_q.delete(); mr_q.delete();
    classify(iw, c, alu, src);
    for (int i = 0; i < dly; i++) push(base(3'd0), 1'b0, 1'($urandom));
    e = base(3'd0); e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(e, 1'b1, 1'($urandom));
    e = base(3'd1);
    case (c)
      C_J:   begin e.jump = 1'b1; e.pc_write = 1'b1; end
      C_JAL: begin e.jump = 1'b1; e.jlink = 1'b1; e.regdst = 2'd2; e.rwr = 1'b1; e.pc_write = 1'b1; end
      C_JR:  begin e.jreg = 1'b1; e.pc_write = 1'b1; end
      C_SYS: e.puts = (vw == 32'd4);
      default: ;
    endcase
    push(e, 1'($urandom), 1'($urandom));
    if (c == C_BAD) begin
      e = base(3'd6); e.ill = 1'b1; push_terminal(e);
    end else if (c == C_SYS && vw == 32'd10) begin
      e = base(3'd5); e.halt = 1'b1; push_terminal(e);
    end else if (c inside {C_R, C_I, C_LW, C_SW, C_BR}) begin
      e = base(3'd2); e.aluop = alu; e.asrc = src;
      if (c == C_BR) begin e.branch = 1'b1; e.pc_write = 1'b1; end
      push(e, 1'($urandom), 1'($urandom));
      if (c == C_LW || c == C_SW) begin
        n = never ? 16 : waits + 1;
        for (int k = 0; k < n; k++) begin
          e = base(3'd3); e.aluop = A_ADD; e.asrc = 1'b1;
          e.mrd = (c == C_LW); e.mwr = (c == C_SW);
          push(e, 1'($urandom), (!never && k == n - 1));
        end
        if (never) begin
          e = base(3'd6); e.tmo = 1'b1; push_terminal(e);
        end
      end
      if (!never && c inside {C_R, C_I, C_LW}) begin
        e = base(3'd4); e.rwr = 1'b1; e.aluop = alu; e.asrc = src;
        e.regdst = (c == C_R) ? 2'd1 : 2'd0; e.m2r = (c == C_LW);
        push(e, 1'($urandom), 1'($urandom));
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      instr       = (iv_q[i] && exp_q[i].st == 3'd0) ? iw : $urandom;
      instr_valid = iv_q[i];
      mem_ready   = mr_q[i];
      vreg        = vw;
      @(negedge clk);
      chk($sformatf("%s[%0d]", tag, i), 32'(obs), 32'(exp_q[i]));
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n       = 1'b0;
    instr_valid = 1'($urandom);
    mem_ready   = 1'($urandom);
    instr       = $urandom;
    #2;
    chk(tag, 32'(obs), 32'(base(3'd0)));
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    instr_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr(input int k, output logic [31:0] vw);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  f;
    logic [31:0] w;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
    vw = $urandom;
    if (vw == 32'd10) vw = 32'd11;
    case (k)
      0: begin
        case ($urandom_range(0, 5))
          0: f = 6'h20; 1: f = 6'h21; 2: f = 6'h22; 3: f = 6'h24; 4: f = 6'h25; default: f = 6'h2A;
        endcase
        w = {6'h00, rs, rt, rd, 5'd0, f};
      end
      1: begin
        case ($urandom_range(0, 4))
          0: f = 6'h08; 1: f = 6'h09; 2: f = 6'h0B; 3: f = 6'h0D; default: f = 6'h0F;
        endcase
        w = {f, rs, rt, imm};
      end
      2: w = {6'h23, rs, rt, imm};
      3: w = {6'h2B, rs, rt, imm};
      4: w = {($urandom_range(0, 1) != 0) ? 6'h05 : 6'h04, rs, rt, imm};
      5: w = {6'h02, 26'($urandom)};
      6: w = {6'h03, 26'($urandom)};
      7: w = {6'h00, rs, 15'd0, 6'h08};
      8: begin
        w = 32'h0000000C;
        if ($urandom_range(0, 1) != 0) vw = 32'd4;
      end
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  initial begin
    logic [31:0] w, vw;
    rst_n = 1'b0; instr = '0; vreg = '0; instr_valid = 1'b0; mem_ready = 1'b0;

    do_reset("reset0");
    run_txn("add", 32'h00851020, 32'd0, 0, 0, 1'b0);
    run_txn("lw_wait3", 32'h8C820004, 32'd0, 0, 3, 1'b0);
    for (int t = 0; t < 40; t++) begin
      w = rand_instr($urandom_range(0, 9), vw);
      run_txn($sformatf("rnd%0d_%h", t, w), w, vw, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end
    run_txn("sw_timeout", 32'hAC820004, 32'd0, 1, 0, 1'b1);

    do_reset("reset_after_tmo");
    run_txn("sys_puts", 32'h0000000C, 32'd4, 0, 0, 1'b0);
    run_txn("sys_exit", 32'h0000000C, 32'd10, 0, 0, 1'b0);

    do_reset("reset_after_halt");
    run_txn("jal", 32'h0C000010, 32'd0, 0, 0, 1'b0);
    run_txn("op3f", 32'hFC000000, 32'd0, 0, 0, 1'b0);

    // Reset pulled while a load is waiting in MEM.
    do_reset("reset_after_ill");
    instr = 32'h8C820004; instr_valid = 1'b1; vreg = '0; mem_ready = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_lw_state", 32'(state), 32'd3);
    chk("mid_lw_memread", 32'(MemRead), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem", 32'(obs), 32'(base(3'd0)));
    @(posedge clk); #1;
    rst_n = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rst_release", 32'(obs), 32'(base(3'd0)));
    @(posedge clk); #1;
    run_txn("add_after_rst", 32'h00851020, 32'd0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
